binary2gray_recon: RTL and testbench

- Reconstructs a 12-bit grey level from the 1-bit binarised pixel stream produced by the thresholding stage. It is the decode direction of that stage.
- Operation: a running box-filter count of ones over the last 2^LOG2_WIN pixels of the current line, scaled to full 12-bit range.
- Position: sits downstream of the binariser, ahead of the VGA/display path. Drives identical R/G/B so the result displays as grey.
- Stream has no backpressure; camera timing drives iValid.

---
 rtl/gray_recon_pkg.sv | 26 ++
 rtl/win_counter.sv | 53 +++++
 rtl/binary2gray_recon.sv | 66 ++++++
 tb/tb_binary2gray_recon.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/gray_recon_pkg.sv
// Shared constants, types and the saturating grey-scale helper for the
// binary-to-grey reconstruction block.
package gray_recon_pkg;

  localparam int DEF_DATA_W   = 12;
  localparam int MAX_LOG2_WIN = 6;

  // Wide enough for any legal window length (up to 64 ones).
  typedef logic [MAX_LOG2_WIN:0] sum_t;

  localparam logic [0:0] ST_FILL   = 1'b0;
  localparam logic [0:0] ST_STEADY = 1'b1;

  // A full window would scale to exactly 2^data_w, which does not fit, so it
  // saturates to all-ones instead of wrapping to zero.
  function automatic logic [31:0] scale_sum(input sum_t sum, input int log2_win,
                                            input int data_w = DEF_DATA_W);
    logic [31:0] s;
    s = 32'(sum);
    if (s == (32'd1 << log2_win))
      scale_sum = (32'd1 << data_w) - 32'd1;
    else
      scale_sum = s << (data_w - log2_win);
  endfunction

endpackage

// File: rtl/win_counter.sv
// Sliding window of the last N pixel bits of the current line with a running
// count of ones and a fill counter; clear takes priority over insert.
module win_counter
  import gray_recon_pkg::*;
#(
  parameter int LOG2_WIN = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                ins,
  input  logic                bit_in,
  output logic [LOG2_WIN:0]   sum_nxt,
  output logic [0:0]          state_nxt
);

  localparam int N  = 1 << LOG2_WIN;
  localparam int SW = LOG2_WIN + 1;
  localparam logic [SW-1:0] N_V = SW'(N);

  logic [N-1:0]  hist_q, hist_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [SW-1:0] fill_q, fill_d;

  always_comb begin
    hist_d = clr ? '0 : hist_q;
    sum_d  = clr ? '0 : sum_q;
    fill_d = clr ? '0 : fill_q;
    if (ins) begin
      // The bit leaving the window is read before the shift; cleared history
      // makes it zero, which gives the zero-pad behaviour at the line edge.
      sum_d  = sum_d + SW'(bit_in) - SW'(hist_d[N-1]);
      hist_d = {hist_d[N-2:0], bit_in};
      fill_d = (fill_d == N_V) ? N_V : fill_d + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      sum_q  <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      sum_q  <= sum_d;
      fill_q <= fill_d;
    end
  end

  assign sum_nxt   = sum_d;
  assign state_nxt = (fill_d == N_V) ? ST_STEADY : ST_FILL;

endmodule

// File: rtl/binary2gray_recon.sv
// Rebuilds a grey level from a binarised pixel stream using a per-line box
// filter; drives equal R/G/B with one cycle of registered latency.
module binary2gray_recon
  import gray_recon_pkg::*;
#(
  parameter int LOG2_WIN = 3,
  parameter int DATA_W   = DEF_DATA_W
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              iValid,
  input  logic              iSOL,
  input  logic              iBit,
  output logic              oValid,
  output logic              oWarm,
  output logic [DATA_W-1:0] oRed,
  output logic [DATA_W-1:0] oGreen,
  output logic [DATA_W-1:0] oBlue
);

  logic [LOG2_WIN:0] sum_nxt;
  logic [0:0]        state_nxt;

  logic              valid_q, valid_d;
  logic              warm_q, warm_d;
  logic [DATA_W-1:0] grey_q, grey_d;

  win_counter #(.LOG2_WIN(LOG2_WIN)) u_win (
    .clk       (iCLK),
    .rst_n     (iRST_n),
    .clr       (iSOL),
    .ins       (iValid),
    .bit_in    (iBit),
    .sum_nxt   (sum_nxt),
    .state_nxt (state_nxt)
  );

  // Colour holds across idle cycles; warm tracks the window even when idle so
  // a start-of-line without a pixel still drops it.
  always_comb begin
    valid_d = iValid;
    warm_d  = (state_nxt == ST_STEADY);
    grey_d  = grey_q;
    if (iValid)
      grey_d = DATA_W'(scale_sum(sum_t'(sum_nxt), LOG2_WIN, DATA_W));
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      valid_q <= 1'b0;
      warm_q  <= 1'b0;
      grey_q  <= '0;
    end else begin
      valid_q <= valid_d;
      warm_q  <= warm_d;
      grey_q  <= grey_d;
    end
  end

  assign oValid = valid_q;
  assign oWarm  = warm_q;
  assign oRed   = grey_q;
  assign oGreen = grey_q;
  assign oBlue  = grey_q;

endmodule

// File: tb/tb_binary2gray_recon.sv
// Bench for binary2gray_recon: a line-history model checked every cycle on two
// builds (window 8 and window 2), plus directed literal expectations.
module tb_binary2gray_recon;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic valid = 1'b0;
  logic sol = 1'b0;
  logic bit_i = 1'b0;

  logic        v0, w0, v1, w1;
  logic [11:0] r0, g0, b0, r1, g1, b1;

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;

  // Model state: all pixels of the current line, newest at the back.
  bit line_q[$];
  int e_red0 = 0;
  int e_red1 = 0;
  bit e_valid = 1'b0;
  bit e_warm0 = 1'b0;
  bit e_warm1 = 1'b0;

  always #5 clk = ~clk;

  binary2gray_recon #(.LOG2_WIN(3), .DATA_W(12)) dut0 (
    .iCLK(clk), .iRST_n(rst_n), .iValid(valid), .iSOL(sol), .iBit(bit_i),
    .oValid(v0), .oWarm(w0), .oRed(r0), .oGreen(g0), .oBlue(b0)
  );

  binary2gray_recon #(.LOG2_WIN(1), .DATA_W(12)) dut1 (
    .iCLK(clk), .iRST_n(rst_n), .iValid(valid), .iSOL(sol), .iBit(bit_i),
    .oValid(v1), .oWarm(w1), .oRed(r1), .oGreen(g1), .oBlue(b1)
  );

  function automatic int model_grey(input int n, input int s);
    if (s == n) return 4095;
    return s * (4096 / n);
  endfunction

  function automatic int win_sum(input int n);
    int s = 0;
    for (int i = 0; i < n && i < line_q.size(); i++)
      s += int'(line_q[line_q.size() - 1 - i]);
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q.delete();
      e_valid <= 1'b0;
      e_warm0 <= 1'b0;
      e_warm1 <= 1'b0;
      e_red0  <= 0;
      e_red1  <= 0;
    end else begin
      if (sol) line_q.delete();
      if (valid) begin
        line_q.push_back(bit_i);
        if (line_q.size() > 64) void'(line_q.pop_front());
        e_red0 <= model_grey(8, win_sum(8));
        e_red1 <= model_grey(2, win_sum(2));
      end
      e_valid <= valid;
      e_warm0 <= (line_q.size() >= 8);
      e_warm1 <= (line_q.size() >= 2);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("m_valid0", int'(v0), int'(e_valid));
      chk("m_warm0",  int'(w0), int'(e_warm0));
      chk("m_red0",   int'(r0), e_red0);
      chk("m_green0", int'(g0), e_red0);
      chk("m_blue0",  int'(b0), e_red0);
      chk("m_valid1", int'(v1), int'(e_valid));
      chk("m_warm1",  int'(w1), int'(e_warm1));
      chk("m_red1",   int'(r1), e_red1);
      chk("m_green1", int'(g1), e_red1);
      chk("m_blue1",  int'(b1), e_red1);
    end
  end

  task automatic pix(input bit s, input bit v, input bit b);
    @(negedge clk);
    sol   = s;
    valid = v;
    bit_i = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_ramp[8];
    exp_ramp = '{512, 1024, 1536, 2048, 2560, 3072, 3584, 4095};

    #1 rst_n = 1'b0;
    #2;
    chk("rst_red0", int'(r0), 0);
    chk("rst_valid0", int'(v0), 0);
    chk("rst_warm0", int'(w0), 0);
    chk("rst_red1", int'(r1), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    started = 1'b1;

    // Ramp of ones from a line start.
    for (int i = 0; i < 8; i++) begin
      pix(i == 0, 1'b1, 1'b1);
      chk("ramp_red0", int'(r0), exp_ramp[i]);
      chk("ramp_warm0", int'(w0), (i == 7) ? 1 : 0);
      chk("ramp_red1", int'(r1), (i == 0) ? 2048 : 4095);
    end

    // Alternating pattern settles at half scale.
    for (int i = 0; i < 20; i++) begin
      pix(i == 0, 1'b1, (i % 2) == 0);
      if (r0 > 12'd2048) chk("alt_max", int'(r0), 2048);
      if (i >= 7) begin
        chk("alt_red0", int'(r0), 2048);
        chk("alt_warm0", int'(w0), 1);
      end
    end

    // Line start drops a full window back to a single pixel.
    for (int i = 0; i < 8; i++) pix(i == 0, 1'b1, 1'b1);
    pix(1'b1, 1'b1, 1'b0);
    chk("sol_red0", int'(r0), 0);
    chk("sol_warm0", int'(w0), 0);
    pix(1'b0, 1'b1, 1'b1);
    chk("sol_next_red0", int'(r0), 512);

    // Idle start-of-line clears but holds colour; repeated start-of-line.
    pix(1'b1, 1'b0, 1'b0);
    chk("sol_idle_valid0", int'(v0), 0);
    chk("sol_idle_red0", int'(r0), 512);
    pix(1'b1, 1'b1, 1'b1);
    chk("sol_b2b_red0", int'(r0), 512);

    // Valid gaps hold the colour.
    pix(1'b1, 1'b1, 1'b1);
    chk("gap_first_red0", int'(r0), 512);
    for (int i = 0; i < 3; i++) begin
      pix(1'b0, 1'b0, 1'b0);
      chk("gap_valid0", int'(v0), 0);
      chk("gap_hold_red0", int'(r0), 512);
    end
    pix(1'b0, 1'b1, 1'b1);
    chk("gap_after_red0", int'(r0), 1024);
    chk("gap_after_valid0", int'(v0), 1);

    // Asynchronous reset in the middle of a line.
    for (int i = 0; i < 5; i++) pix(i == 0, 1'b1, 1'b1);
    chk("mid_red0", int'(r0), 2560);
    @(negedge clk);
    valid = 1'b0;
    sol = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_red0", int'(r0), 0);
    chk("arst_valid0", int'(v0), 0);
    chk("arst_warm0", int'(w0), 0);
    chk("arst_red1", int'(r1), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pix(1'b0, 1'b1, 1'b1);
    chk("post_rst_red0", int'(r0), 512);
    chk("post_rst_warm0", int'(w0), 0);

    pix(1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
